// File: rtl/virtual_input_sequencer.sv
// Queues 8-bit virtual-input commands in a 4-deep FIFO and replays each one as a
// number/control strobe sequence for the decoder. Define VIN_PULSE_EN to enable press/release pulses.
module virtual_input_sequencer #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int PRESS_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [4:0] number,
    output logic       control,
    output logic       busy,
    output logic       err
);

    localparam int CMAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

`ifdef VIN_PULSE_EN
    localparam int PW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
    localparam logic [PW-1:0] PRESS_LAST = PW'(PRESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        PRESS  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [4:0]      cur_idx;
    logic [4:0]      number_p1;
    logic            control_p1;

    logic [4:0]      idx_mem [4];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count;
    logic            ready_en;
    logic            accept, cmd_bad, push, pop;

`ifdef VIN_PULSE_EN
    logic            pulse_mem [4];
    logic            cur_pulse;
    logic            rel, rel_n;
    logic [PW-1:0]   pcnt, pcnt_n;
`else
    logic            unused_pulse_flag;
    assign unused_pulse_flag = cmd_data[7];
`endif

    // Reserved bits set, or an index outside the decoder's map (31 is clear-all and stays legal)
    assign cmd_bad   = ((cmd_data[4:0] >= 5'd22) && (cmd_data[4:0] <= 5'd30)) ||
                       (cmd_data[6:5] != 2'b00);
    assign cmd_ready = ready_en && (count != 3'd4);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && !cmd_bad;
    assign busy      = (state != IDLE) || (count != 3'd0);

    always_ff @(posedge clock) begin
        if (push) begin
            idx_mem[wr_ptr] <= cmd_data[4:0];
`ifdef VIN_PULSE_EN
            pulse_mem[wr_ptr] <= cmd_data[7] && (cmd_data[4:0] != 5'd31);
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
`ifdef VIN_PULSE_EN
        rel_n   = rel;
        pcnt_n  = pcnt;
`endif
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop     = 1'b1;
                    cnt_n   = '0;
                    state_n = SETUP;
`ifdef VIN_PULSE_EN
                    rel_n   = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = STROBE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STROBE: begin
                if (cnt == STROBE_LAST) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef VIN_PULSE_EN
                    if (cur_pulse && !rel) begin
                        state_n = PRESS;
                        pcnt_n  = '0;
                    end
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef VIN_PULSE_EN
            PRESS: begin
                if (pcnt == PRESS_LAST) begin
                    state_n = SETUP;
                    rel_n   = 1'b1;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count      <= 3'd0;
            err        <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            cur_idx    <= 5'd0;
            number_p1  <= 5'd0;
            control_p1 <= 1'b0;
`ifdef VIN_PULSE_EN
            cur_pulse  <= 1'b0;
            rel        <= 1'b0;
            pcnt       <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            err      <= accept && cmd_bad;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) begin
                cur_idx <= idx_mem[rd_ptr];
`ifdef VIN_PULSE_EN
                cur_pulse <= pulse_mem[rd_ptr];
`endif
            end
`ifdef VIN_PULSE_EN
            rel  <= rel_n;
            pcnt <= pcnt_n;
`endif
            // Output stage: decoder pins trail the FSM by one registered cycle
            number_p1  <= cur_idx;
            control_p1 <= (state == STROBE);
        end
    end

    assign number  = number_p1;
    assign control = control_p1;

endmodule

// File: tb/tb_virtual_input_sequencer.sv
// Directed and randomized bench for virtual_input_sequencer; strobes are captured
// on the decoder pins and compared with a command-list model.
module tb_virtual_input_sequencer;

    localparam int SETUP  = 2;
    localparam int STROBE = 4;
    localparam int PRESS  = 1000;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [4:0] number;
    logic       control;
    logic       busy;
    logic       err;

    virtual_input_sequencer #(
        .SETUP_CYCLES (SETUP),
        .STROBE_CYCLES(STROBE),
        .PRESS_CYCLES (PRESS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .number   (number),
        .control  (control),
        .busy     (busy),
        .err      (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    int rise_num[$];
    int rise_cyc[$];
    int hi_len[$];
    int err_seen = 0;
    int num_viol = 0;
    int hi_cnt = 0;
    logic ctl_prev = 1'b0;
    logic [4:0] num_prev = 5'd0;

    // Strobe monitor on the falling edge
    always @(negedge clock) begin
        if (control && !ctl_prev) begin
            rise_num.push_back(int'(number));
            rise_cyc.push_back(cyc);
            hi_cnt = 0;
        end
        if (control) hi_cnt++;
        if (!control && ctl_prev) hi_len.push_back(hi_cnt);
        if (control && ctl_prev && (number != num_prev)) num_viol++;
        if (err) err_seen++;
        ctl_prev = control;
        num_prev = number;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int acc_edge;
    int stall_cycles;

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) check("push_timeout", 32'd1, 32'd0);
        stall_cycles += n;
        acc_edge = cyc + 1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_log();
        rise_num.delete();
        rise_cyc.delete();
        hi_len.delete();
        err_seen = 0;
    endtask

    int exp_q[$];
    int exp_err;
    int base;
    logic [7:0] six_cmds [6];

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        stall_cycles = 0;
        repeat (3) @(negedge clock);
        check("rst_number", 32'(number), 32'd0);
        check("rst_control", 32'(control), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        check("ready_after_edge", 32'(cmd_ready), 32'd1);

        // Single command: latency, setup and strobe width
        clear_log();
        push(8'h05);
        wait_idle();
        check("s1_rises", 32'(rise_num.size()), 32'd1);
        if (rise_num.size() >= 1) begin
            check("s1_number", 32'(rise_num[0]), 32'd5);
            check("s1_latency", 32'(rise_cyc[0] - acc_edge), 32'(SETUP + 2));
            check("s1_width", 32'(hi_len[0]), 32'(STROBE));
        end
        check("s1_busy_after", 32'(busy), 32'd0);
        check("s1_number_held", 32'(number), 32'd5);

        // Rejected commands
        clear_log();
        push(8'h16);
        push(8'h45);
        repeat (10) @(negedge clock);
        check("rej_err_count", 32'(err_seen), 32'd2);
        check("rej_rises", 32'(rise_num.size()), 32'd0);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_ready", 32'(cmd_ready), 32'd1);

        // Clear-all, with and without pulse flag
        clear_log();
        push(8'h1F);
        wait_idle();
        push(8'h9F);
        wait_idle();
        check("clr_rises", 32'(rise_num.size()), 32'd2);
        if (rise_num.size() == 2) begin
            check("clr_num0", 32'(rise_num[0]), 32'd31);
            check("clr_num1", 32'(rise_num[1]), 32'd31);
        end

        // Pulse flag on an ordinary index
        clear_log();
        push(8'h80);
        wait_idle();
`ifdef VIN_PULSE_EN
        check("pulse_rises", 32'(rise_num.size()), 32'd2);
        if (rise_num.size() == 2) begin
            check("pulse_num0", 32'(rise_num[0]), 32'd0);
            check("pulse_num1", 32'(rise_num[1]), 32'd0);
            check("pulse_gap", 32'(rise_cyc[1] - rise_cyc[0]), 32'(STROBE + SETUP + PRESS + SETUP));
            check("pulse_width1", 32'(hi_len[1]), 32'(STROBE));
        end
`else
        check("pulse_ignored_rises", 32'(rise_num.size()), 32'd1);
        if (rise_num.size() == 1) check("pulse_ignored_num", 32'(rise_num[0]), 32'd0);
`endif

        // Six back-to-back commands overflow the FIFO
        clear_log();
        six_cmds[0] = 8'h01; six_cmds[1] = 8'h02; six_cmds[2] = 8'h03;
        six_cmds[3] = 8'h04; six_cmds[4] = 8'h07; six_cmds[5] = 8'h09;
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) push(six_cmds[i]);
        check("b2b_stalled", 32'(stall_cycles > 0), 32'd1);
        wait_idle();
        check("b2b_rises", 32'(rise_num.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < rise_num.size()) check("b2b_order", 32'(rise_num[i]), 32'(six_cmds[i][4:0]));
        if (rise_cyc.size() == 6)
            check("b2b_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'(STROBE + SETUP + 1 + SETUP));

        // Reset in the middle of a strobe, with another command queued
        clear_log();
        push(8'h0A);
        push(8'h03);
        begin
            int n;
            n = 0;
            while (!control && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("mid_reached_strobe", 32'(control), 32'd1);
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_control_drop", 32'(control), 32'd0);
        check("mid_number", 32'(number), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        base = rise_num.size();
        check("mid_first_num", 32'(rise_num[0]), 32'd10);
        repeat (60) @(negedge clock);
        check("mid_no_resume", 32'(rise_num.size() - base), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        // Randomized commands against the command-list model
        clear_log();
        exp_q.delete();
        exp_err = 0;
        num_viol = 0;
        for (int i = 0; i < 40; i++) begin
            logic [4:0] idx;
            logic [1:0] res;
            logic       pls;
            idx = 5'($urandom_range(0, 31));
            res = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            pls = ($urandom_range(0, 7) == 0);
            if ((idx >= 5'd22 && idx <= 5'd30) || res != 2'd0) begin
                exp_err++;
            end else begin
                exp_q.push_back(int'(idx));
`ifdef VIN_PULSE_EN
                if (pls && idx != 5'd31) exp_q.push_back(int'(idx));
`endif
            end
            push({pls, res, idx});
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_idle();
        check("rnd_rises", 32'(rise_num.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rise_num.size()) check("rnd_index", 32'(rise_num[i]), 32'(exp_q[i]));
        check("rnd_err", 32'(err_seen), 32'(exp_err));
        check("rnd_number_stable", 32'(num_viol), 32'd0);
        begin
            int bad_w;
            bad_w = 0;
            foreach (hi_len[i]) if (hi_len[i] != STROBE) bad_w++;
            check("rnd_widths", 32'(bad_w), 32'd0);
        end
        check("rnd_busy_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
